// File: rtl/calendar_set_if.sv
// ============================================================================
// Module : calendar_set_if
// Brief  : Edit/tick inputs and BCD calendar outputs of calendar_set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface calendar_set_if #(
  parameter int YEAR_DIGITS = 2
);
  logic                       day_tick;
  logic [1:0]                 field_sel;
  logic                       inc;
  logic                       dec;
  logic [3:0]                 date_t;
  logic [3:0]                 date_s;
  logic [3:0]                 mon_t;
  logic [3:0]                 mon_s;
  logic [4*YEAR_DIGITS-1:0]   year_bcd;
  logic                       year_wrap;

  modport master (
    output day_tick, field_sel, inc, dec,
    input  date_t, date_s, mon_t, mon_s, year_bcd, year_wrap
  );

  modport slave (
    input  day_tick, field_sel, inc, dec,
    output date_t, date_s, mon_t, mon_s, year_bcd, year_wrap
  );
endinterface

`default_nettype wire

// File: rtl/calendar_set.sv
// ============================================================================
// Module : calendar_set
// Brief  : Settable BCD date/month/year calendar advanced by day_tick.
//          Leap-year February is enabled by macro CAL_LEAP_YEAR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module calendar_set #(
  parameter int YEAR_DIGITS = 2,
  parameter int RST_MON     = 1,
  parameter int RST_DATE    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  calendar_set_if.slave bus
);

  localparam int              YW           = 4 * YEAR_DIGITS;
  localparam logic [3:0]      C_RST_DATE_T = 4'(RST_DATE / 10);
  localparam logic [3:0]      C_RST_DATE_S = 4'(RST_DATE % 10);
  localparam logic [3:0]      C_RST_MON_T  = 4'(RST_MON / 10);
  localparam logic [3:0]      C_RST_MON_S  = 4'(RST_MON % 10);
  localparam logic [YW-1:0]   C_YEAR_MAX   = {YEAR_DIGITS{4'h9}};

  logic [3:0]    date_t_q, date_t_d, date_s_q, date_s_d;
  logic [3:0]    mon_t_q, mon_t_d, mon_s_q, mon_s_d;
  logic [YW-1:0] year_q, year_d;
  logic          year_wrap_q, year_wrap_d;

  logic [4:0]    date_bin, mon_bin, cur_max;
  logic [4:0]    date_n, mon_n, new_max, date_c;
  logic          edit;
  logic          leap_cur, leap_new;

  function automatic logic [4:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] s);
    logic [4:0] base;
    case (t)
      4'd1:    base = 5'd10;
      4'd2:    base = 5'd20;
      4'd3:    base = 5'd30;
      default: base = 5'd0;
    endcase
    return base + {1'b0, s};
  endfunction

  // Ones digit via mod-16 arithmetic: the true remainder always fits in 4 bits.
  function automatic logic [7:0] bin_to_bcd(input logic [4:0] v);
    if (v >= 5'd30)      return {4'd3, v[3:0] - 4'd14};
    else if (v >= 5'd20) return {4'd2, v[3:0] - 4'd4};
    else if (v >= 5'd10) return {4'd1, v[3:0] - 4'd10};
    else                 return {4'd0, v[3:0]};
  endfunction

  function automatic logic [4:0] max_day(input logic [4:0] m, input logic leap);
    case (m)
      5'd2:                     return leap ? 5'd29 : 5'd28;
      5'd4, 5'd6, 5'd9, 5'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  function automatic logic [YW-1:0] year_step(input logic [YW-1:0] y, input logic up);
    logic [YW-1:0] r;
    logic          carry;
    r     = y;
    carry = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (y[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = y[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (y[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = y[4*i +: 4] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

`ifdef CAL_LEAP_YEAR_EN
  // A two-digit BCD number is a multiple of 4 iff (tens even, ones 0/4/8) or (tens odd, ones 2/6).
  function automatic logic div4(input logic tens_odd, input logic [3:0] ones);
    if (tens_odd) return (ones == 4'd2) || (ones == 4'd6);
    else          return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

  generate
    if (YEAR_DIGITS == 4) begin : g_leap4
      always_comb begin
        leap_cur = div4(year_q[4], year_q[3:0]) &&
                   ((year_q[7:0] != 8'h00) || div4(year_q[12], year_q[11:8]));
        leap_new = div4(year_d[4], year_d[3:0]) &&
                   ((year_d[7:0] != 8'h00) || div4(year_d[12], year_d[11:8]));
      end
    end else begin : g_leap2
      always_comb begin
        leap_cur = div4(year_q[4], year_q[3:0]);
        leap_new = div4(year_d[4], year_d[3:0]);
      end
    end
  endgenerate
`else
  assign leap_cur = 1'b0;
  assign leap_new = 1'b0;
`endif

  assign date_bin = bcd_to_bin(date_t_q, date_s_q);
  assign mon_bin  = bcd_to_bin(mon_t_q, mon_s_q);
  assign cur_max  = max_day(mon_bin, leap_cur);
  assign edit     = (bus.inc ^ bus.dec) && (bus.field_sel != 2'd3);

  // Edits win over day_tick; a tick coinciding with an edit is dropped.
  always_comb begin
    date_n      = date_bin;
    mon_n       = mon_bin;
    year_d      = year_q;
    year_wrap_d = 1'b0;
    if (edit) begin
      case (bus.field_sel)
        2'd0: begin
          if (bus.inc) date_n = (date_bin >= cur_max) ? 5'd1 : date_bin + 5'd1;
          else         date_n = (date_bin <= 5'd1) ? cur_max : date_bin - 5'd1;
        end
        2'd1: begin
          if (bus.inc) mon_n = (mon_bin >= 5'd12) ? 5'd1 : mon_bin + 5'd1;
          else         mon_n = (mon_bin <= 5'd1) ? 5'd12 : mon_bin - 5'd1;
        end
        2'd2:    year_d = year_step(year_q, bus.inc);
        default: ;
      endcase
    end else if (bus.day_tick) begin
      if (date_bin >= cur_max) begin
        date_n = 5'd1;
        if (mon_bin >= 5'd12) begin
          mon_n       = 5'd1;
          year_d      = year_step(year_q, 1'b1);
          year_wrap_d = (year_q == C_YEAR_MAX);
        end else begin
          mon_n = mon_bin + 5'd1;
        end
      end else begin
        date_n = date_bin + 5'd1;
      end
    end
  end

  // Clamp against the month and year that will be registered this cycle.
  always_comb begin
    new_max              = max_day(mon_n, leap_new);
    date_c               = (date_n > new_max) ? new_max : date_n;
    {date_t_d, date_s_d} = bin_to_bcd(date_c);
    {mon_t_d, mon_s_d}   = bin_to_bcd(mon_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      date_t_q    <= C_RST_DATE_T;
      date_s_q    <= C_RST_DATE_S;
      mon_t_q     <= C_RST_MON_T;
      mon_s_q     <= C_RST_MON_S;
      year_q      <= '0;
      year_wrap_q <= 1'b0;
    end else begin
      date_t_q    <= date_t_d;
      date_s_q    <= date_s_d;
      mon_t_q     <= mon_t_d;
      mon_s_q     <= mon_s_d;
      year_q      <= year_d;
      year_wrap_q <= year_wrap_d;
    end
  end

  assign bus.date_t    = date_t_q;
  assign bus.date_s    = date_s_q;
  assign bus.mon_t     = mon_t_q;
  assign bus.mon_s     = mon_s_q;
  assign bus.year_bcd  = year_q;
  assign bus.year_wrap = year_wrap_q;

endmodule

`default_nettype wire

// File: doc/calendar_set.md
CALENDAR_SET -- requirements
Module: calendar_set

Interface
REQ-001 The module SHALL have parameter YEAR_DIGITS, default 2, giving the number of BCD year digits; the only legal values are 2 and 4.
REQ-002 The module SHALL have parameter RST_MON, default 1, giving the binary reset month (1..12).
REQ-003 The module SHALL have parameter RST_DATE, default 1, giving the binary reset date (1..28).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port day_tick, input, 1 bit: a single-cycle pulse that advances the calendar by one day.
REQ-007 The module SHALL have port field_sel, input, 2 bits, selecting the field to edit: 0 date, 1 month, 2 year, 3 none.
REQ-008 The module SHALL have port inc, input, 1 bit: a single-cycle pulse that increments the selected field.
REQ-009 The module SHALL have port dec, input, 1 bit: a single-cycle pulse that decrements the selected field.
REQ-010 The module SHALL have outputs date_t and date_s, 4 bits each: BCD tens and ones of the date.
REQ-011 The module SHALL have outputs mon_t and mon_s, 4 bits each: BCD tens and ones of the month.
REQ-012 The module SHALL have output year_bcd, 4*YEAR_DIGITS bits: the BCD year, least-significant digit in the low nibble.
REQ-013 The module SHALL have output year_wrap, 1 bit: a one-cycle pulse raised when the year rolls over from its maximum value to 0.

Function
REQ-014 All outputs SHALL be registered, and every update SHALL appear on the clk edge after the causing input.
REQ-015 Every digit SHALL always hold a legal BCD value (0..9); the date SHALL always lie in 1..max_day(month, year); the month SHALL always lie in 1..12.
REQ-016 max_day SHALL be:
- 31 for months 1, 3, 5, 7, 8, 10, 12;
- 30 for months 4, 6, 9, 11;
- 28 or 29 for month 2, as set by REQ-027 and REQ-028.
REQ-017 When exactly one of inc or dec is high, field_sel=0 and day_tick is low, the date SHALL change by one; inc wraps max_day to 01 and dec wraps 01 to max_day.
REQ-018 When exactly one of inc or dec is high and field_sel=1, the month SHALL change by one with wraps 12->01 and 01->12; year_wrap stays 0.
REQ-019 When exactly one of inc or dec is high and field_sel=2, the year SHALL change by one, wrapping between the maximum value (99 or 9999) and 0; year_wrap stays 0 on edits.
REQ-020 After any month or year change, the date SHALL be clamped in the same cycle to max_day of the new month and year (example: 31/03, dec month -> 28/02 or 29/02).
REQ-021 When inc and dec are both high, or field_sel=3, no edit SHALL occur.
REQ-022 An active edit (exactly one of inc or dec, field_sel 0..2) SHALL take priority over day_tick, and a day_tick arriving in that cycle SHALL be dropped.
REQ-023 day_tick with no active edit SHALL increment the date.
- At max_day, the date goes to 01 and the month increments.
- From month 12, the month goes to 01 and the year increments.
- At the maximum year, the year goes to 0 and year_wrap pulses for one cycle.
REQ-024 Tens digits SHALL be updated coherently with ones digits in the same cycle, so no intermediate value is ever visible.

Reset
REQ-025 While rst_n=0, the outputs SHALL asynchronously take:
- month = RST_MON and date = RST_DATE, both in BCD;
- year_bcd = 0;
- year_wrap = 0.
REQ-026 Inputs SHALL be ignored while rst_n is low; the first update SHALL occur on the first clk edge after rst_n rises. Reset asserted mid-operation SHALL abort any pending update.

Configuration
REQ-027 With macro CAL_LEAP_YEAR_EN defined, February SHALL have 29 days in a leap year and 28 days otherwise.
- YEAR_DIGITS=2: leap means year divisible by 4, with 00 counted as leap.
- YEAR_DIGITS=4: leap means divisible by 4 and (not divisible by 100 or divisible by 400).
- Divisibility SHALL be computed directly on the BCD digits.
REQ-028 With CAL_LEAP_YEAR_EN undefined, February SHALL always have 28 days and no leap logic SHALL be synthesised.

Verification
REQ-029 Reset scenario: pulse rst_n low with RST_MON=1, RST_DATE=1 -> outputs 01/01, year 00, year_wrap=0, held through release.
REQ-030 Month-end scenario: set 30/04, apply one day_tick -> 01/05; set 31/12/99, apply one day_tick -> 01/01/00 with year_wrap high for exactly one cycle.
REQ-031 Leap scenario with CAL_LEAP_YEAR_EN, YEAR_DIGITS=4: year 2000, 28/02 plus day_tick -> 29/02; year 1900, 28/02 plus day_tick -> 01/03. Without the macro, year 2000, 28/02 plus day_tick -> 01/03.
REQ-032 Clamp scenario: at 31/01, set field_sel=1 and pulse inc -> 28/02 (29/02 in a leap year with the macro defined); at 31/05, pulse dec on the month -> 30/04.
REQ-033 Conflict scenario: at 15/06, field_sel=0 with inc and day_tick in the same cycle -> 16/06 (the tick is dropped); inc and dec together -> 15/06 unchanged.
REQ-034 Wrap scenario: at 01/01, pulse dec on the date -> 31/01; at month 01, pulse dec on the month -> 12; at year 00, pulse dec on the year -> 99 with year_wrap=0.
